// File: rtl/inv_sub_bytes_state.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes_state
//   InvSubBytes stage of the AES-128 decryption datapath. Keeps the 16-byte
//   state in a local memory. The upstream InvShiftRows stage loads it one byte
//   at a time. A start pulse then replaces every byte in place with
//   InvSBox(byte). When the pass ends, add_flag pulses to hand the state over
//   to AddRoundKey.
//
//   The S-box is computed arithmetically: a GF(2^8) inverse (x^254) combined
//   with the affine map. No 256-entry ROM is used.
//
// Parameters
//   PIPE_SBOX        1: S-box result and index are registered and written back
//                       one edge later (pass adds one DRAIN cycle).
//                    0: read-modify-write on the same edge.
//   RESET_CLEAR_MEM  1: reset clears the 16 state bytes to 8'h00.
//                    0: reset leaves the memory untouched.
//
// Optional feature (macro SUB_BYTES_FWD_MODE_EN)
//   Adds input fwd_mode. It is captured with an accepted start and held for
//   the whole pass. 1 selects the forward S-box and 0 the inverse S-box.
//   Without the macro only the inverse S-box exists.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      one-cycle pulse, begins a pass (accepted only in IDLE, hold low)
//   wr_in      external byte write strobe (accepted only in IDLE, hold low)
//   addr_in    external write address 0..15
//   data_in    external write data
//   rd_addr    read address for data_out
//   hold       stall: freezes FSM, counter and pipeline, blocks memory writes
//   data_out   mem[rd_addr], combinational
//   busy       high while a pass is in flight (RUN/DRAIN)
//   count_out  byte index currently issued
//   add_flag   one-cycle pulse when a pass completes
// -----------------------------------------------------------------------------
module inv_sub_bytes_state #(
  parameter bit PIPE_SBOX       = 1'b1,
  parameter bit RESET_CLEAR_MEM = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
`ifdef SUB_BYTES_FWD_MODE_EN
  input  logic       fwd_mode,
`endif
  input  logic       start,
  input  logic       wr_in,
  input  logic [3:0] addr_in,
  input  logic [7:0] data_in,
  input  logic [3:0] rd_addr,
  input  logic       hold,
  output logic [7:0] data_out,
  output logic       busy,
  output logic [3:0] count_out,
  output logic       add_flag
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // GF(2^8) multiply by x, modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      else      acc = acc;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse; it also maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] base;
    logic [7:0] e;
    r    = 8'h01;
    base = a;
    e    = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, base);
      else      r = r;
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

`ifdef SUB_BYTES_FWD_MODE_EN
  // Forward affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic fwd);
    if (fwd) return fwd_affine(gf_inv(b));
    else     return gf_inv(inv_affine(b));
  endfunction
`else
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return gf_inv(inv_affine(b));
  endfunction
`endif

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       add_flag_q, add_flag_d;
  logic       busy_q, busy_d;
  logic       pv_q, pv_d;          // pipeline writeback pending
  logic [3:0] pidx_q, pidx_d;
  logic [7:0] pdata_q, pdata_d;
  logic [7:0] mem_q [16];

  logic [7:0] rd_byte_s;
  logic [7:0] sub_byte_s;
  logic       mem_we_s;
  logic [3:0] mem_waddr_s;
  logic [7:0] mem_wdata_s;

  assign rd_byte_s = mem_q[count_q];

`ifdef SUB_BYTES_FWD_MODE_EN
  logic mode_q, mode_d;
  assign sub_byte_s = sub_byte(rd_byte_s, mode_q);
`else
  assign sub_byte_s = sub_byte(rd_byte_s);
`endif

  // Next-state logic for FSM, byte counter, completion flag and pipeline stage
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    add_flag_d = 1'b0;
    pv_d       = pv_q;
    pidx_d     = pidx_q;
    pdata_d    = pdata_q;
`ifdef SUB_BYTES_FWD_MODE_EN
    mode_d     = mode_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !hold) begin
          state_d = S_RUN;
          count_d = 4'd0;
`ifdef SUB_BYTES_FWD_MODE_EN
          mode_d  = fwd_mode;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!hold) begin
          pv_d    = PIPE_SBOX;
          pidx_d  = count_q;
          pdata_d = sub_byte_s;
          if (count_q == 4'd15) begin
            if (PIPE_SBOX) begin
              state_d = S_DRAIN;
            end else begin
              state_d    = S_IDLE;
              count_d    = 4'd0;
              add_flag_d = 1'b1;
            end
          end else begin
            count_d = count_q + 4'd1;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (!hold) begin
          pv_d       = 1'b0;
          state_d    = S_IDLE;
          count_d    = 4'd0;
          add_flag_d = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = 4'd0;
        pv_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Memory write port: external load in IDLE, otherwise the substitution path
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = addr_in;
    mem_wdata_s = data_in;
    if (hold) begin
      mem_we_s = 1'b0;
    end else if (state_q == S_IDLE) begin
      mem_we_s = wr_in;
    end else if (PIPE_SBOX) begin
      // Writeback of i-1 while i is being read: addresses never collide
      mem_we_s    = pv_q;
      mem_waddr_s = pidx_q;
      mem_wdata_s = pdata_q;
    end else if (state_q == S_RUN) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = count_q;
      mem_wdata_s = sub_byte_s;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Control and pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      count_q    <= 4'd0;
      add_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      pv_q       <= 1'b0;
      pidx_q     <= 4'd0;
      pdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      add_flag_q <= add_flag_d;
      busy_q     <= busy_d;
      pv_q       <= pv_d;
      pidx_q     <= pidx_d;
      pdata_q    <= pdata_d;
    end
  end

`ifdef SUB_BYTES_FWD_MODE_EN
  // S-box direction latched for the duration of a pass
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mode_q <= 1'b0;
    else      mode_q <= mode_d;
  end
`endif

  if (RESET_CLEAR_MEM) begin : g_mem_clr
    // State memory, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
      end else if (mem_we_s) begin
        mem_q[mem_waddr_s] <= mem_wdata_s;
      end
    end
  end else begin : g_mem_keep
    // State memory, contents survive reset; writes suppressed while in reset
    always_ff @(posedge clk) begin
      if (mem_we_s && rst) mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign data_out  = mem_q[rd_addr];
  assign busy      = busy_q;
  assign count_out = count_q;
  assign add_flag  = add_flag_q;

endmodule
